// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine transaction controller.
// Coin values, change codes and the cents-to-code mapping live here.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_VEND,
        ST_CHANGE,
        ST_REFUND
    } state_e;

    localparam logic [5:0] NICKEL_CENTS  = 6'd5;
    localparam logic [5:0] DIME_CENTS    = 6'd10;
    localparam logic [5:0] QUARTER_CENTS = 6'd25;

    localparam logic [2:0] CODE_0  = 3'b000;
    localparam logic [2:0] CODE_5  = 3'b001;
    localparam logic [2:0] CODE_10 = 3'b010;
    localparam logic [2:0] CODE_15 = 3'b011;
    localparam logic [2:0] CODE_20 = 3'b100;

    // Values outside the 0..20 nickel grid collapse to "no change".
    function automatic logic [2:0] cents_to_code(input logic [5:0] cents);
        logic [2:0] code;
        case (cents)
            6'd5:    code = CODE_5;
            6'd10:   code = CODE_10;
            6'd15:   code = CODE_15;
            6'd20:   code = CODE_20;
            default: code = CODE_0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/vend_ctrl_price_compare.sv
// Combinational price check on a candidate credit value.
// Flags when the price is reached and encodes the surplus as a change code.
module price_compare
    import vend_pkg::*;
#(
    parameter int PRICE = 20
) (
    input  logic [5:0] credit_i,
    output logic       reached_o,
    output logic [2:0] code_o
);

    localparam logic [5:0] PRICE_C = 6'(PRICE);

    logic [5:0] surplus;

    assign reached_o = (credit_i >= PRICE_C);
    assign surplus   = credit_i - PRICE_C;
    assign code_o    = reached_o ? cents_to_code(surplus) : CODE_0;

endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction controller: coin accumulation, vend and change handshakes,
// cancel/timeout refund. All outputs come straight from registers.
//
// state      | meaning
// IDLE       | no credit held, waiting for a first coin
// COLLECT    | partial credit held, timeout counter running
// VEND       | price reached, item request outstanding
// CHANGE     | item taken, surplus change request outstanding
// REFUND     | cancel/timeout, returning the held credit
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE   = 20,
    parameter int TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       nickel_i,
    input  logic       dime_i,
    input  logic       quarter_i,
    input  logic       cancel_i,
    input  logic       item_ready_i,
    input  logic       change_ready_i,
    output logic       item_valid_o,
    output logic       change_valid_o,
    output logic [2:0] change_o,
    output logic [5:0] credit_o,
    output logic       coin_reject_o,
    output logic       busy_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [5:0]    credit_q, credit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    code_q, code_d;
    logic          item_valid_q, item_valid_d;
    logic          change_valid_q, change_valid_d;
    logic [2:0]    change_q, change_d;
    logic          reject_q, reject_d;
    logic          busy_q, busy_d;

    logic [1:0] n_coins;
    logic       any_coin;
    logic       accepting;
    logic       coin_ok;
    logic [5:0] coin_val;
    logic [5:0] next_credit;
    logic       reached;
    logic [2:0] next_code;

    assign n_coins   = {1'b0, nickel_i} + {1'b0, dime_i} + {1'b0, quarter_i};
    assign any_coin  = nickel_i | dime_i | quarter_i;
    assign accepting = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
    assign coin_ok   = (n_coins == 2'd1) && accepting && !cancel_i;

    always_comb begin
        coin_val = 6'd0;
        if (nickel_i)       coin_val = NICKEL_CENTS;
        else if (dime_i)    coin_val = DIME_CENTS;
        else if (quarter_i) coin_val = QUARTER_CENTS;
    end

    assign next_credit = credit_q + coin_val;

    price_compare #(.PRICE(PRICE)) u_price_compare (
        .credit_i  (next_credit),
        .reached_o (reached),
        .code_o    (next_code)
    );

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        case (state_q)
            ST_IDLE: begin
                // A cancel with nothing held is simply ignored.
                if (coin_ok) begin
                    credit_d = next_credit;
                    cnt_d    = '0;
                    if (reached) begin
                        state_d = ST_VEND;
                        code_d  = next_code;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                if (cancel_i) begin
                    state_d = ST_REFUND;
                end else if (coin_ok) begin
                    credit_d = next_credit;
                    cnt_d    = '0;
                    if (reached) begin
                        state_d = ST_VEND;
                        code_d  = next_code;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_REFUND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_VEND: begin
                if (item_valid_q && item_ready_i) begin
                    if (code_q != CODE_0) begin
                        state_d = ST_CHANGE;
                    end else begin
                        state_d  = ST_IDLE;
                        credit_d = 6'd0;
                    end
                end
            end
            ST_CHANGE, ST_REFUND: begin
                if (change_valid_q && change_ready_i) begin
                    state_d  = ST_IDLE;
                    credit_d = 6'd0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                credit_d = 6'd0;
            end
        endcase
    end

    // Outputs are registered images of the next state so they line up with it.
    always_comb begin
        item_valid_d   = (state_d == ST_VEND);
        change_valid_d = (state_d == ST_CHANGE) || (state_d == ST_REFUND);
        change_d       = CODE_0;
        if (state_d == ST_CHANGE)      change_d = code_d;
        else if (state_d == ST_REFUND) change_d = cents_to_code(credit_d);
        busy_d   = item_valid_d | change_valid_d;
        reject_d = any_coin && !coin_ok;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            credit_q       <= 6'd0;
            cnt_q          <= '0;
            code_q         <= CODE_0;
            item_valid_q   <= 1'b0;
            change_valid_q <= 1'b0;
            change_q       <= CODE_0;
            reject_q       <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            cnt_q          <= cnt_d;
            code_q         <= code_d;
            item_valid_q   <= item_valid_d;
            change_valid_q <= change_valid_d;
            change_q       <= change_d;
            reject_q       <= reject_d;
            busy_q         <= busy_d;
        end
    end

    assign item_valid_o   = item_valid_q;
    assign change_valid_o = change_valid_q;
    assign change_o       = change_q;
    assign credit_o       = credit_q;
    assign coin_reject_o  = reject_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: directed scenarios plus randomized traffic, all checked
// against a cents-level transaction model of the controller's rules.
module tb_vend_ctrl;

    localparam int PRICE   = 20;
    localparam int TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       nickel, dime, quarter, cancel;
    logic       item_ready, change_ready;
    logic       item_valid_o, change_valid_o;
    logic [2:0] change_o;
    logic [5:0] credit_o;
    logic       coin_reject_o, busy_o;

    vend_ctrl #(.PRICE(PRICE), .TIMEOUT(TIMEOUT)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .nickel_i       (nickel),
        .dime_i         (dime),
        .quarter_i      (quarter),
        .cancel_i       (cancel),
        .item_ready_i   (item_ready),
        .change_ready_i (change_ready),
        .item_valid_o   (item_valid_o),
        .change_valid_o (change_valid_o),
        .change_o       (change_o),
        .credit_o       (credit_o),
        .coin_reject_o  (coin_reject_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [12:0] act_vec;
    logic [12:0] exp_vec = '0;
    assign act_vec = {item_valid_o, change_valid_o, change_o, credit_o, coin_reject_o, busy_o};

    // Transaction model: credit in cents, plus which request is outstanding.
    int m_credit = 0;
    int m_quiet = 0;
    int m_change_cents = 0;
    bit m_vending = 0, m_changing = 0, m_refunding = 0, m_reject = 0;

    task automatic model_step();
        int ncoins, value;
        bit busy;
        int code;
        if (!rst_n) begin
            m_credit = 0; m_quiet = 0; m_change_cents = 0;
            m_vending = 0; m_changing = 0; m_refunding = 0; m_reject = 0;
            exp_vec = '0;
            return;
        end
        ncoins = int'(nickel) + int'(dime) + int'(quarter);
        value  = 5 * int'(nickel) + 10 * int'(dime) + 25 * int'(quarter);
        busy   = m_vending | m_changing | m_refunding;
        m_reject = (ncoins > 0) && (ncoins > 1 || busy || cancel);
        if (m_vending) begin
            if (item_ready) begin
                m_vending = 0;
                if (m_change_cents > 0) m_changing = 1;
                else m_credit = 0;
            end
        end else if (m_changing) begin
            if (change_ready) begin m_changing = 0; m_credit = 0; end
        end else if (m_refunding) begin
            if (change_ready) begin m_refunding = 0; m_credit = 0; end
        end else begin
            if (cancel && m_credit > 0) begin
                m_refunding = 1;
            end else if (ncoins == 1 && !cancel) begin
                m_credit = m_credit + value;
                m_quiet = 0;
                if (m_credit >= PRICE) begin
                    m_vending = 1;
                    m_change_cents = m_credit - PRICE;
                end
            end else if (m_credit > 0) begin
                if (m_quiet == TIMEOUT - 1) m_refunding = 1;
                else m_quiet++;
            end
        end
        code = m_changing ? m_change_cents / 5 : (m_refunding ? m_credit / 5 : 0);
        busy = m_vending | m_changing | m_refunding;
        exp_vec = {m_vending, m_changing | m_refunding, 3'(code), 6'(m_credit), m_reject, busy};
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        nickel = 0; dime = 0; quarter = 0; cancel = 0;
        item_ready = 0; change_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        tick(); tick();
        n_cmp++;
        if (act_vec !== 13'd0) begin
            n_bad++; $display("FAIL reset_outputs: got %h expected 0", act_vec);
        end
        rst_n = 1;
        tick();
        n_cmp++;
        if (act_vec !== exp_vec) begin
            n_bad++; $display("FAIL reset_idle: got %h expected %h", act_vec, exp_vec);
        end
    endtask

    task automatic test_nickels();
        item_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            nickel = 1; tick(); nickel = 0;
            n_cmp++;
            if (credit_o !== 6'(5 * i) || act_vec !== exp_vec) begin
                n_bad++; $display("FAIL nickels_step%0d: got credit %0d vec %h expected credit %0d vec %h",
                                  i, credit_o, act_vec, 5 * i, exp_vec);
            end
        end
        n_cmp++;
        if (item_valid_o !== 1'b1) begin
            n_bad++; $display("FAIL nickels_vend: got item_valid %b expected 1", item_valid_o);
        end
        tick();
        n_cmp++;
        if (item_valid_o !== 1'b0 || change_valid_o !== 1'b0 || credit_o !== 6'd0 || act_vec !== exp_vec) begin
            n_bad++; $display("FAIL nickels_done: got %h expected %h", act_vec, exp_vec);
        end
        idle_inputs();
    endtask

    task automatic test_dime_quarter();
        dime = 1; tick(); dime = 0;
        quarter = 1; tick(); quarter = 0;
        n_cmp++;
        if (credit_o !== 6'd35 || item_valid_o !== 1'b1 || act_vec !== exp_vec) begin
            n_bad++; $display("FAIL dq_vend: got %h expected %h", act_vec, exp_vec);
        end
        item_ready = 1; tick(); item_ready = 0;
        n_cmp++;
        if (change_valid_o !== 1'b1 || change_o !== 3'b011 || item_valid_o !== 1'b0) begin
            n_bad++; $display("FAIL dq_change: got valid %b code %b expected 1 011", change_valid_o, change_o);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (change_o !== 3'b011 || change_valid_o !== 1'b1 || act_vec !== exp_vec) begin
                n_bad++; $display("FAIL dq_hold%0d: got %h expected %h", k, act_vec, exp_vec);
            end
        end
        change_ready = 1; tick(); change_ready = 0;
        n_cmp++;
        if (change_valid_o !== 1'b0 || credit_o !== 6'd0 || busy_o !== 1'b0) begin
            n_bad++; $display("FAIL dq_idle: got %h expected %h", act_vec, exp_vec);
        end
    endtask

    task automatic test_forty_and_double();
        nickel = 1; tick(); nickel = 0;
        dime = 1; tick(); dime = 0;
        nickel = 1; dime = 1; tick(); nickel = 0; dime = 0;
        n_cmp++;
        if (coin_reject_o !== 1'b1 || credit_o !== 6'd15) begin
            n_bad++; $display("FAIL double_coin: got reject %b credit %0d expected 1 15", coin_reject_o, credit_o);
        end
        quarter = 1; tick(); quarter = 0;
        n_cmp++;
        if (credit_o !== 6'd40 || coin_reject_o !== 1'b0 || item_valid_o !== 1'b1) begin
            n_bad++; $display("FAIL forty_vend: got %h expected %h", act_vec, exp_vec);
        end
        item_ready = 1; tick(); item_ready = 0;
        n_cmp++;
        if (change_o !== 3'b100 || change_valid_o !== 1'b1) begin
            n_bad++; $display("FAIL forty_change: got code %b expected 100", change_o);
        end
        change_ready = 1; tick(); change_ready = 0;
        n_cmp++;
        if (act_vec !== exp_vec || credit_o !== 6'd0) begin
            n_bad++; $display("FAIL forty_idle: got %h expected %h", act_vec, exp_vec);
        end
    endtask

    task automatic test_cancel();
        dime = 1; tick(); dime = 0;
        nickel = 1; cancel = 1; tick(); nickel = 0; cancel = 0;
        n_cmp++;
        if (coin_reject_o !== 1'b1 || change_valid_o !== 1'b1 || change_o !== 3'b010 || credit_o !== 6'd10) begin
            n_bad++; $display("FAIL cancel_refund: got %h expected %h", act_vec, exp_vec);
        end
        change_ready = 1; tick(); change_ready = 0;
        n_cmp++;
        if (act_vec !== exp_vec || busy_o !== 1'b0 || credit_o !== 6'd0) begin
            n_bad++; $display("FAIL cancel_idle: got %h expected %h", act_vec, exp_vec);
        end
    endtask

    task automatic test_timeout();
        nickel = 1; tick(); nickel = 0;
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            n_cmp++;
            if (change_valid_o !== 1'b0 || credit_o !== 6'd5) begin
                n_bad++; $display("FAIL timeout_early%0d: got %h expected %h", k, act_vec, exp_vec);
            end
        end
        tick();
        n_cmp++;
        if (change_valid_o !== 1'b1 || change_o !== 3'b001 || busy_o !== 1'b1) begin
            n_bad++; $display("FAIL timeout_refund: got %h expected %h", act_vec, exp_vec);
        end
        quarter = 1; tick(); quarter = 0;
        n_cmp++;
        if (coin_reject_o !== 1'b1 || credit_o !== 6'd5 || change_o !== 3'b001) begin
            n_bad++; $display("FAIL timeout_quarter: got %h expected %h", act_vec, exp_vec);
        end
        change_ready = 1; tick(); change_ready = 0;
        n_cmp++;
        if (act_vec !== exp_vec || credit_o !== 6'd0) begin
            n_bad++; $display("FAIL timeout_idle: got %h expected %h", act_vec, exp_vec);
        end
    endtask

    task automatic test_reset_mid_vend();
        dime = 1; tick(); tick(); dime = 0;
        quarter = 1; tick(); quarter = 0;
        n_cmp++;
        if (coin_reject_o !== 1'b1 || item_valid_o !== 1'b1 || credit_o !== 6'd20) begin
            n_bad++; $display("FAIL vend_quarter: got %h expected %h", act_vec, exp_vec);
        end
        rst_n = 0; tick(); rst_n = 1;
        n_cmp++;
        if (act_vec !== 13'd0) begin
            n_bad++; $display("FAIL midreset_outputs: got %h expected 0", act_vec);
        end
        quarter = 1; tick(); quarter = 0;
        n_cmp++;
        if (credit_o !== 6'd25 || item_valid_o !== 1'b1) begin
            n_bad++; $display("FAIL midreset_quarter: got %h expected %h", act_vec, exp_vec);
        end
        item_ready = 1; tick(); item_ready = 0;
        n_cmp++;
        if (change_o !== 3'b001 || change_valid_o !== 1'b1) begin
            n_bad++; $display("FAIL midreset_change: got code %b expected 001", change_o);
        end
        change_ready = 1; tick(); change_ready = 0;
        n_cmp++;
        if (act_vec !== exp_vec) begin
            n_bad++; $display("FAIL midreset_idle: got %h expected %h", act_vec, exp_vec);
        end
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 1500; c++) begin
            r = $urandom_range(0, 99);
            nickel  = (r < 12) || (r >= 30 && r < 33);
            dime    = (r >= 12 && r < 22) || (r >= 30 && r < 32);
            quarter = (r >= 22 && r < 30) || (r == 33);
            cancel       = ($urandom_range(0, 19) == 0);
            item_ready   = $urandom_range(0, 1) == 1;
            change_ready = $urandom_range(0, 1) == 1;
            rst_n        = ($urandom_range(0, 299) != 0);
            tick();
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_bad++; $display("FAIL random_cycle%0d: got %h expected %h", c, act_vec, exp_vec);
            end
        end
        rst_n = 1;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_nickels();
        test_dime_quarter();
        test_forty_and_double();
        test_cancel();
        test_timeout();
        test_reset_mid_vend();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Vending-machine transaction controller: accepts coin pulses, accumulates credit and compares it against a fixed price using the 5-cent change encoding. It sequences vend and change-return handshakes toward the dispenser mechanics. Cancel and inactivity timeout refund the held credit. It sits between the coin acceptor and the item and change dispensers, and owns the price-comparison datapath.

## Interface
- PRICE, 20, item price in cents; multiple of 5, ≤ 40
- TIMEOUT, 255, idle cycles in COLLECT before auto-refund; ≥ 2
- clk_i  in  1  clock
- rst_ni  in  1  synchronous, active-low reset
- nickel_i  in  1  5-cent coin pulse, one cycle
- dime_i  in  1  10-cent coin pulse
- quarter_i  in  1  25-cent coin pulse
- cancel_i  in  1  refund request pulse
- item_ready_i  in  1  item dispenser accepts vend
- change_ready_i  in  1  change dispenser accepts code
- item_valid_o  out  1  vend request, held until accepted
- change_valid_o  out  1  change/refund request, held until accepted
- change_o  out  3  coded amount: 000=0, 001=5, 010=10, 011=15, 100=20
- credit_o  out  6  current credit in cents
- coin_reject_o  out  1  one-cycle pulse: coin returned, not credited
- busy_o  out  1  high in VEND, CHANGE, REFUND

## Operation
- States: IDLE, COLLECT, VEND, CHANGE, REFUND.
- Reset: state IDLE, credit 0, timeout counter 0, every output 0.
- Coin is legal only when exactly one coin input is high, state is IDLE or COLLECT, and cancel_i is low. Otherwise every asserted coin is rejected: coin_reject_o = 1 on the next cycle and credit is unchanged.
- Legal coin: next_credit = credit + value (5, 10 or 25).
  - If next_credit ≥ PRICE: go to VEND and latch the change code of next_credit − PRICE.
  - Otherwise: go to COLLECT.
  - The timeout counter reloads to 0.
- Arithmetic: credit never exceeds PRICE − 5 + 25 = 40, so it fits in 6 bits. Change values are always 0–20 in multiples of 5. Any other value maps to code 000.
- COLLECT: counter increments each cycle without a legal coin.
  - Counter = TIMEOUT − 1: go to REFUND.
  - cancel_i: go to REFUND; cancel takes priority over a same-cycle coin, which is rejected.
- IDLE with cancel_i: ignored; no refund of 0.
- VEND: item_valid_o = 1. On item_valid_o & item_ready_i, go to CHANGE if the latched code ≠ 000, else to IDLE with credit cleared.
- CHANGE: change_valid_o = 1 and change_o = latched code, held stable. On handshake, go to IDLE with credit cleared.
- REFUND: change_valid_o = 1 and change_o = code(credit); credit ≤ 15 here. On handshake, go to IDLE with credit cleared.
- cancel_i in VEND, CHANGE or REFUND is ignored; a transaction committed to vend cannot be cancelled.
- Mid-operation reset (rst_ni low at any edge) returns to reset values with no handshake completion. Credit is lost by design.

## Timing
- All outputs are registered.
- Coin sampled at edge N: credit_o and state update at N+1; item_valid_o is high from N+1 when the price is reached.
- coin_reject_o: high for exactly the cycle after the offending edge.
- Handshake completes at the edge where valid & ready. valid deasserts from the next cycle.
- valid is never dependent on ready; ready may be high before valid.
- VEND→CHANGE: change_valid_o rises the cycle after item acceptance.
- Minimum transaction: coin at N, item accepted at N+1, change accepted at N+2, IDLE at N+3.
- Timeout: REFUND is entered exactly TIMEOUT cycles after the last accepted coin.

## Structure
- Shared package vend_pkg:
  - state enum
  - coin value constants (5, 10, 25)
  - change code constants
  - function mapping a 6-bit cents value to the 3-bit code
- Sub-module price_compare (combinational): 6-bit credit in; reached-price flag and 3-bit change code out. Parameterized by PRICE and instantiated once on next_credit.
- Remaining logic in vend_ctrl: FSM, credit register, timeout counter, output registers.

## Test plan
- Nickel ×4 with item_ready_i = 1: credit_o steps 5, 10, 15, 20. item_valid_o pulses one cycle after the 4th coin. No change_valid_o. Returns to IDLE with credit 0.
- Dime then quarter (credit 35): VEND, then CHANGE with change_o = 011. Hold change_ready_i low 3 cycles: change_o stays stable and valid stays high.
- Nickel + dime (15), then quarter (40): change_o = 100. Also drive nickel_i & dime_i together: coin_reject_o pulses and credit stays unchanged.
- Dime, then cancel_i asserted the same cycle as a nickel: REFUND with change_o = 010, the nickel is rejected, IDLE after handshake.
- Nickel, then no activity with TIMEOUT = 4: REFUND exactly 4 cycles after the coin, change_o = 001. A quarter inserted during VEND/REFUND is rejected.
- Dime + dime, then rst_ni low during VEND with item_ready_i = 0: next cycle all outputs 0, state IDLE. A subsequent quarter gives credit_o = 25 and change code 001.
